alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/sys_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_pkg.sv
// Shared definitions for the ALU arbiter: controller state encoding,
// the reserved "illegal" function code and a counter sizing helper.
package sys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAKE = 3'd1,
        ST_EXEC = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } arb_state_e;

    // Function code of all ones is reserved as illegal; users slice this
    // down to their own function-code width.
    localparam int unsigned FUN_W_MAX = 32;
    localparam logic [FUN_W_MAX-1:0] FUN_ILLEGAL_ALL = '1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The pointer names the requester that wins a
// tie; it is moved away from whoever was just served.
module rr_arb2 (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_id_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    logic ptr_q;
    logic ptr_d;

    assign ptr_d = upd_i ? ~upd_id_i : ptr_q;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt_vld_o = |req_i;
        if (&req_i) begin
            gnt_id_o = ptr_q;
        end else begin
            gnt_id_o = req_i[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clock-gated ALU between two requesters: grant, wake the ALU
// clock, pulse enable, wait (bounded) for the result, return a tagged response.
module alu_arbiter
    import sys_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FUN_WIDTH  = 4,
    parameter int unsigned TMO_CYCLES = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_REQ0_Valid,
    input  logic [DATA_WIDTH-1:0]   i_REQ0_A,
    input  logic [DATA_WIDTH-1:0]   i_REQ0_B,
    input  logic [FUN_WIDTH-1:0]    i_REQ0_FUN,
    input  logic                    i_REQ1_Valid,
    input  logic [DATA_WIDTH-1:0]   i_REQ1_A,
    input  logic [DATA_WIDTH-1:0]   i_REQ1_B,
    input  logic [FUN_WIDTH-1:0]    i_REQ1_FUN,
    output logic                    o_REQ0_Ready,
    output logic                    o_REQ1_Ready,
    output logic                    o_RSP_Valid,
    output logic                    o_RSP_ID,
    output logic [2*DATA_WIDTH-1:0] o_RSP_Data,
    output logic                    o_RSP_Err,
    output logic [DATA_WIDTH-1:0]   o_ALU_A,
    output logic [DATA_WIDTH-1:0]   o_ALU_B,
    output logic [FUN_WIDTH-1:0]    o_ALU_FUN,
    output logic                    o_ALU_Enable,
    output logic                    o_ALU_CLK_EN,
    input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
    input  logic                    i_ALU_OUT_Valid,
    output arb_state_e              o_DBG_State
);

    localparam int unsigned CNT_W = cnt_width(TMO_CYCLES);
    localparam logic [FUN_WIDTH-1:0] FUN_ILLEGAL = FUN_ILLEGAL_ALL[FUN_WIDTH-1:0];
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TMO_CYCLES);

    arb_state_e              state_q;
    logic                    id_q;
    logic [CNT_W-1:0]        tmo_q;
    logic                    rdy0_q;
    logic                    rdy1_q;
    logic                    rsp_vld_q;
    logic                    rsp_id_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;
    logic                    rsp_err_q;
    logic [DATA_WIDTH-1:0]   alu_a_q;
    logic [DATA_WIDTH-1:0]   alu_b_q;
    logic [FUN_WIDTH-1:0]    alu_fun_q;
    logic                    alu_en_q;
    logic                    clk_en_q;

    logic                    gnt_vld;
    logic                    gnt_id;
    logic [DATA_WIDTH-1:0]   alu_a_d;
    logic [DATA_WIDTH-1:0]   alu_b_d;
    logic [FUN_WIDTH-1:0]    alu_fun_d;

    // Handshake: a requester raises Valid with stable A/B/FUN and keeps them
    // until it sees Ready; the single Ready cycle is the acceptance cycle.
    // Ready is registered, so the winner's operands are captured on the edge
    // that raises Ready, while the requester is still required to hold them.
    rr_arb2 u_rr_arb2 (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .req_i     ({i_REQ1_Valid, i_REQ0_Valid}),
        .upd_i     (state_q == ST_RESP),
        .upd_id_i  (id_q),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    assign alu_a_d   = gnt_id ? i_REQ1_A   : i_REQ0_A;
    assign alu_b_d   = gnt_id ? i_REQ1_B   : i_REQ0_B;
    assign alu_fun_d = gnt_id ? i_REQ1_FUN : i_REQ0_FUN;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q    <= ST_IDLE;
            id_q       <= 1'b0;
            tmo_q      <= '0;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            clk_en_q   <= 1'b0;
        end else begin
            rdy0_q    <= 1'b0;
            rdy1_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            alu_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        rdy0_q    <= ~gnt_id;
                        rdy1_q    <= gnt_id;
                        id_q      <= gnt_id;
                        alu_a_q   <= alu_a_d;
                        alu_b_q   <= alu_b_d;
                        alu_fun_q <= alu_fun_d;
                        if (alu_fun_d == FUN_ILLEGAL) begin
                            state_q    <= ST_RESP;
                            rsp_vld_q  <= 1'b1;
                            rsp_id_q   <= gnt_id;
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                        end else begin
                            clk_en_q <= 1'b1;
                            state_q  <= ST_WAKE;
                        end
                    end
                end
                ST_WAKE: begin
                    alu_en_q <= 1'b1;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    tmo_q   <= TMO_LOAD;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result in the same cycle as expiry still wins.
                    if (i_ALU_OUT_Valid) begin
                        state_q    <= ST_RESP;
                        clk_en_q   <= 1'b0;
                        rsp_vld_q  <= 1'b1;
                        rsp_id_q   <= id_q;
                        rsp_data_q <= i_ALU_OUT;
                        rsp_err_q  <= 1'b0;
                    end else if (tmo_q <= CNT_W'(1)) begin
                        state_q    <= ST_RESP;
                        clk_en_q   <= 1'b0;
                        rsp_vld_q  <= 1'b1;
                        rsp_id_q   <= id_q;
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    clk_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_REQ0_Ready = rdy0_q;
    assign o_REQ1_Ready = rdy1_q;
    assign o_RSP_Valid  = rsp_vld_q;
    assign o_RSP_ID     = rsp_id_q;
    assign o_RSP_Data   = rsp_data_q;
    assign o_RSP_Err    = rsp_err_q;
    assign o_ALU_A      = alu_a_q;
    assign o_ALU_B      = alu_b_q;
    assign o_ALU_FUN    = alu_fun_q;
    assign o_ALU_Enable = alu_en_q;
    assign o_ALU_CLK_EN = clk_en_q;
    assign o_DBG_State  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter with a behavioural ALU, a round-robin
// reference and a response scoreboard keyed on expected cycle of arrival.
module tb_alu_arbiter;
    import sys_pkg::*;

    localparam int DW  = 8;
    localparam int FW  = 4;
    localparam int TMO = 4;
    localparam int RW  = 2 * DW;
    localparam int EW  = 32 + 2 + RW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid [2];
    logic [DW-1:0] req_a [2];
    logic [DW-1:0] req_b [2];
    logic [FW-1:0] req_fun [2];
    logic          rdy0, rdy1;
    logic          rsp_valid, rsp_id, rsp_err;
    logic [RW-1:0] rsp_data;
    logic [DW-1:0] alu_a, alu_b;
    logic [FW-1:0] alu_fun;
    logic          alu_en, alu_clk_en;
    logic [RW-1:0] alu_out;
    logic          alu_vld;
    logic          spur;
    arb_state_e    dbg_state;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            en_count = 0;
    int            rsp_count = 0;
    int            alu_lat = 1;
    logic          alu_never = 1'b0;
    int            alu_cnt = 0;
    logic [RW-1:0] alu_res;

    logic [EW-1:0] exp_q[$];
    logic          grant_log[$];
    logic          prev_v [2];
    logic          last_served = 1'b1;
    logic          prev_en = 1'b0;
    logic          prev_ce = 1'b0;
    logic          last_id = 1'b0;
    logic          last_err = 1'b0;
    logic [RW-1:0] last_data = '0;

    alu_arbiter #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .TMO_CYCLES(TMO)) dut (
        .i_CLK           (clk),
        .i_RST           (rst_n),
        .i_REQ0_Valid    (req_valid[0]),
        .i_REQ0_A        (req_a[0]),
        .i_REQ0_B        (req_b[0]),
        .i_REQ0_FUN      (req_fun[0]),
        .i_REQ1_Valid    (req_valid[1]),
        .i_REQ1_A        (req_a[1]),
        .i_REQ1_B        (req_b[1]),
        .i_REQ1_FUN      (req_fun[1]),
        .o_REQ0_Ready    (rdy0),
        .o_REQ1_Ready    (rdy1),
        .o_RSP_Valid     (rsp_valid),
        .o_RSP_ID        (rsp_id),
        .o_RSP_Data      (rsp_data),
        .o_RSP_Err       (rsp_err),
        .o_ALU_A         (alu_a),
        .o_ALU_B         (alu_b),
        .o_ALU_FUN       (alu_fun),
        .o_ALU_Enable    (alu_en),
        .o_ALU_CLK_EN    (alu_clk_en),
        .i_ALU_OUT       (alu_out),
        .i_ALU_OUT_Valid (alu_vld | spur),
        .o_DBG_State     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running want=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [RW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [FW-1:0] f);
        case (f)
            4'd0:    return RW'(a) + RW'(b);
            4'd1:    return RW'(a) - RW'(b);
            4'd2:    return RW'(a) * RW'(b);
            4'd3:    return RW'(a & b);
            4'd4:    return RW'(a | b);
            default: return {a, b};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [FW-1:0] f);
        int n = 0;
        logic seen = 1'b0;
        req_a[id]     = a;
        req_b[id]     = b;
        req_fun[id]   = f;
        req_valid[id] = 1'b1;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = (id == 0) ? rdy0 : rdy1;
        end
        check($sformatf("accept_req%0d", id), seen, 1'b1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        tick(2);
    endtask

    // ---------------- behavioural ALU ----------------
    initial begin
        alu_vld = 1'b0;
        alu_out = '0;
        forever begin
            @(posedge clk);
            #1;
            alu_vld = 1'b0;
            alu_out = RW'($urandom);
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0) begin
                    alu_vld = 1'b1;
                    alu_out = alu_res;
                end
            end
            if (alu_en && !alu_never) begin
                alu_cnt = alu_lat;
                alu_res = alu_ref(alu_a, alu_b, alu_fun);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic          id, exp_id, ill, err;
        logic [FW-1:0] f;
        logic [RW-1:0] data;
        int            when;
        logic [EW-1:0] e;
        if (!rst_n) begin
            last_served = 1'b1;
            prev_en     = 1'b0;
            prev_ce     = 1'b0;
            last_id     = 1'b0;
            last_err    = 1'b0;
            last_data   = '0;
        end else begin
            if (rdy0 || rdy1) begin
                id = rdy1;
                check("ready_onehot", rdy0 & rdy1, 1'b0);
                check("valid_at_ready", req_valid[id], 1'b1);
                exp_id = (prev_v[0] && prev_v[1]) ? ~last_served : prev_v[1];
                check("arb_winner", id, exp_id);
                last_served = id;
                grant_log.push_back(id);
                f    = req_fun[id];
                ill  = (f == {FW{1'b1}});
                err  = ill || alu_never;
                data = err ? '0 : alu_ref(req_a[id], req_b[id], f);
                // Ready marks WAKE; EXEC and WAIT follow, then the result cycle.
                when = ill ? cyc : (alu_never ? cyc + 2 + TMO : cyc + 2 + alu_lat);
                exp_q.push_back({32'(when), err, id, data});
            end
            if (rsp_valid) begin
                rsp_count++;
                check("clk_en_off_in_resp", alu_clk_en, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", rsp_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", rsp_id, e[RW]);
                    check("rsp_err", rsp_err, e[RW+1]);
                    check("rsp_data", rsp_data, e[RW-1:0]);
                    check("rsp_cycle", cyc, e[EW-1 -: 32]);
                end
                last_id   = rsp_id;
                last_err  = rsp_err;
                last_data = rsp_data;
            end else begin
                check("hold_rsp", {rsp_id, rsp_err, rsp_data}, {last_id, last_err, last_data});
            end
            if (alu_en) begin
                en_count++;
                check("clk_en_with_en", alu_clk_en, 1'b1);
                check("clk_en_before_en", prev_ce, 1'b1);
                check("en_single_cycle", prev_en, 1'b0);
            end
            prev_en = alu_en;
            prev_ce = alu_clk_en;
        end
        prev_v[0] = req_valid[0];
        prev_v[1] = req_valid[1];
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int rc;
        int en_before;
        spur = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_a[i]     = '0;
            req_b[i]     = '0;
            req_fun[i]   = '0;
            prev_v[i]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_ready", {rdy1, rdy0}, 2'b00);
        check("rst_alu_en", {alu_en, alu_clk_en}, 2'b00);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_state", dbg_state, ST_IDLE);

        // Both requesters valid from reset: grants alternate starting at 0.
        alu_lat = 1;
        fork
            begin
                send(0, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 4)));
                send(0, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 4)));
            end
            begin
                send(1, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 4)));
                send(1, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 4)));
            end
            begin
                repeat (2) @(negedge clk);
                check("no_grant_in_reset", {rdy1, rdy0}, 2'b00);
                rst_n = 1'b1;
            end
        join
        drain();
        check("rr_len", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("rr_order_%0d", i), grant_log[i], i % 2);
        end

        // Single request 5 + 3, ALU latency 1.
        grant_log.delete();
        send(0, 8'd5, 8'd3, 4'b0000);
        drain();
        check("basic_rsp_count", rsp_count, 5);
        check("basic_last_data", last_data, 16'd8);

        // Illegal function code: error response, ALU never enabled.
        en_before = en_count;
        send(1, DW'($urandom), DW'($urandom), 4'b1111);
        drain();
        check("illegal_no_enable", en_count, en_before);

        // ALU silent: timeout error TMO cycles after WAIT entry.
        alu_never = 1'b1;
        send(0, 8'd7, 8'd9, 4'd2);
        drain();
        alu_never = 1'b0;

        // Stray ALU valid while idle.
        rc = rsp_count;
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("spur_state", dbg_state, ST_IDLE);
        end
        check("spur_no_rsp", rsp_count, rc);
        tick(1);

        // Reset while waiting on the ALU.
        alu_never = 1'b1;
        send(0, 8'hA5, 8'h5A, 4'd0);
        n = 0;
        while (dbg_state != ST_WAIT && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", dbg_state, ST_WAIT);
        @(posedge clk);
        #2;
        rc = rsp_count;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_ready", {rdy1, rdy0}, 2'b00);
        check("rst_mid_rsp", {rsp_valid, rsp_id, rsp_err}, 3'b000);
        check("rst_mid_rsp_data", rsp_data, '0);
        check("rst_mid_alu_ops", {alu_a, alu_b, alu_fun}, '0);
        check("rst_mid_alu_ctl", {alu_en, alu_clk_en}, 2'b00);
        check("rst_mid_state", dbg_state, ST_IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        alu_never = 1'b0;
        tick(6);
        check("rst_no_rsp", rsp_count, rc);
        send(1, 8'd12, 8'd4, 4'd1);
        drain();

        // Randomised traffic: two latency rounds, then a timeout round.
        for (int r = 0; r < 3; r++) begin
            alu_lat   = $urandom_range(1, TMO);
            alu_never = (r == 2);
            fork
                repeat (r == 2 ? 3 : 12) begin
                    tick($urandom_range(0, 3));
                    send(0, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 15)));
                end
                repeat (r == 2 ? 3 : 12) begin
                    tick($urandom_range(0, 3));
                    send(1, DW'($urandom), DW'($urandom), FW'($urandom_range(0, 15)));
                end
            join
            drain();
        end
        alu_never = 1'b0;

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
